// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX operand forwarding
// from EX/MEM and MEM/WB, and load-use hazard detection.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ID_ReadData1,
  input  logic [31:0] ID_ReadData2,
  input  logic [31:0] ID_SignImm,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_Rd,
  input  logic [1:0]  ID_ALUOp,
  input  logic [5:0]  ID_Funct,
  input  logic        ID_ALUSrc,
  input  logic        ID_RegDst,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_MemtoReg,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_WriteReg,
  input  logic [31:0] MEM_ALUResult,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_Result,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALUControl,
  output logic [31:0] EX_StoreData,
  output logic [4:0]  EX_WriteReg,
  output logic        EX_RegWrite,
  output logic        EX_MemRead,
  output logic        EX_MemWrite,
  output logic        EX_MemtoReg,
  output logic        HazardStall
);

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_fields_t;

  ex_fields_t ex_q, ex_d;
  ex_fields_t bubble;
  ex_fields_t id_fields;
  logic [3:0] id_alu_ctrl;
  logic [31:0] fwd_rs, fwd_rt;

  // A bubble is the reset image: no side effects, ALU code parked on add.
  always_comb begin
    bubble          = '0;
    bubble.alu_ctrl = 4'b0010;
  end

  always_comb begin
    id_alu_ctrl = 4'b0010;
    case (ID_ALUOp)
      2'b00: id_alu_ctrl = 4'b0010;
      2'b01: id_alu_ctrl = 4'b0110;
      2'b11: id_alu_ctrl = 4'b0001;
      default: begin
        case (ID_Funct)
          6'b100000: id_alu_ctrl = 4'b0010;
          6'b100010: id_alu_ctrl = 4'b0110;
          6'b100100: id_alu_ctrl = 4'b0000;
          6'b100101: id_alu_ctrl = 4'b0001;
          6'b101010: id_alu_ctrl = 4'b0111;
          6'b100111: id_alu_ctrl = 4'b1100;
          default:   id_alu_ctrl = 4'b0010;
        endcase
      end
    endcase
  end

  always_comb begin
    id_fields            = '0;
    id_fields.rd1        = ID_ReadData1;
    id_fields.rd2        = ID_ReadData2;
    id_fields.imm        = ID_SignImm;
    id_fields.rs         = ID_Rs;
    id_fields.rt         = ID_Rt;
    id_fields.wreg       = ID_RegDst ? ID_Rd : ID_Rt;
    id_fields.alu_ctrl   = id_alu_ctrl;
    id_fields.alu_src    = ID_ALUSrc;
    id_fields.reg_write  = ID_RegWrite;
    id_fields.mem_read   = ID_MemRead;
    id_fields.mem_write  = ID_MemWrite;
    id_fields.mem_to_reg = ID_MemtoReg;
  end

  assign HazardStall = ex_q.mem_read && (ex_q.rt != 5'd0) &&
                       ((ex_q.rt == ID_Rs) || (ex_q.rt == ID_Rt));

  // Flush outranks Stall so a squashed instruction never lingers in EX.
  always_comb begin
    ex_d = ex_q;
    if (Flush)
      ex_d = bubble;
    else if (Stall)
      ex_d = ex_q;
    else if (HazardStall)
      ex_d = bubble;
    else
      ex_d = id_fields;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ex_q <= bubble;
    else
      ex_q <= ex_d;
  end

  always_comb begin
    fwd_rs = ex_q.rd1;
    if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == ex_q.rs))
      fwd_rs = MEM_ALUResult;
    else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == ex_q.rs))
      fwd_rs = WB_Result;
  end

  always_comb begin
    fwd_rt = ex_q.rd2;
    if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == ex_q.rt))
      fwd_rt = MEM_ALUResult;
    else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == ex_q.rt))
      fwd_rt = WB_Result;
  end

  assign A            = fwd_rs;
  assign B            = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign EX_StoreData = fwd_rt;
  assign ALUControl   = ex_q.alu_ctrl;
  assign EX_WriteReg  = ex_q.wreg;
  assign EX_RegWrite  = ex_q.reg_write;
  assign EX_MemRead   = ex_q.mem_read;
  assign EX_MemWrite  = ex_q.mem_write;
  assign EX_MemtoReg  = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run compared against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignImm;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [1:0]  ID_ALUOp;
  logic [5:0]  ID_Funct;
  logic        ID_ALUSrc, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg;
  logic        Stall, Flush;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_WriteReg;
  logic [31:0] MEM_ALUResult;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_Result;
  logic [31:0] A, B, EX_StoreData;
  logic [3:0]  ALUControl;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, HazardStall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignImm(ID_SignImm),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_ALUOp(ID_ALUOp), .ID_Funct(ID_Funct),
    .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg),
    .Stall(Stall), .Flush(Flush),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg), .MEM_ALUResult(MEM_ALUResult),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_Result(WB_Result),
    .A(A), .B(B), .ALUControl(ALUControl), .EX_StoreData(EX_StoreData),
    .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_MemtoReg(EX_MemtoReg), .HazardStall(HazardStall)
  );

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, wr;
    logic [3:0]  alu;
    logic        src, rw, mr, mw, m2r;
  } minst_t;

  minst_t m;

  function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic minst_t ref_bubble();
    minst_t b;
    b = '{rd1: 32'd0, rd2: 32'd0, imm: 32'd0, rs: 5'd0, rt: 5'd0, wr: 5'd0,
          alu: 4'b0010, src: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0};
    return b;
  endfunction

  function automatic logic ref_hazard();
    return m.mr && (m.rt != 0) && (m.rt == ID_Rs || m.rt == ID_Rt);
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] latched);
    if (idx == 0) return latched;
    if (MEM_RegWrite && MEM_WriteReg == idx) return MEM_ALUResult;
    if (WB_RegWrite && WB_WriteReg == idx) return WB_Result;
    return latched;
  endfunction

  // Advance one clock edge, updating the model with the same rules as the hardware.
  task automatic tick();
    minst_t nxt;
    if (!rst_n || Flush) nxt = ref_bubble();
    else if (Stall) nxt = m;
    else if (ref_hazard()) nxt = ref_bubble();
    else begin
      nxt.rd1 = ID_ReadData1; nxt.rd2 = ID_ReadData2; nxt.imm = ID_SignImm;
      nxt.rs = ID_Rs; nxt.rt = ID_Rt; nxt.wr = ID_RegDst ? ID_Rd : ID_Rt;
      nxt.alu = ref_alu(ID_ALUOp, ID_Funct);
      nxt.src = ID_ALUSrc; nxt.rw = ID_RegWrite; nxt.mr = ID_MemRead;
      nxt.mw = ID_MemWrite; nxt.m2r = ID_MemtoReg;
    end
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic clear_id();
    ID_ReadData1 = 0; ID_ReadData2 = 0; ID_SignImm = 0;
    ID_Rs = 0; ID_Rt = 0; ID_Rd = 0; ID_ALUOp = 0; ID_Funct = 0;
    ID_ALUSrc = 0; ID_RegDst = 0; ID_RegWrite = 0; ID_MemRead = 0;
    ID_MemWrite = 0; ID_MemtoReg = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; Stall = 0; Flush = 0;
    MEM_RegWrite = 0; MEM_WriteReg = 0; MEM_ALUResult = 0;
    WB_RegWrite = 0; WB_WriteReg = 0; WB_Result = 0;
    ID_ReadData1 = 32'hDEAD_BEEF; ID_ReadData2 = 32'hCAFE_F00D; ID_SignImm = 32'h1234;
    ID_Rs = 3; ID_Rt = 4; ID_Rd = 7; ID_ALUOp = 2'b10; ID_Funct = 6'b100111;
    ID_ALUSrc = 1; ID_RegDst = 1; ID_RegWrite = 1; ID_MemRead = 1;
    ID_MemWrite = 1; ID_MemtoReg = 1;
    m = ref_bubble();
    tick();
    tick();
    n_cmp++; if (A !== 32'd0) begin n_err++; $display("FAIL reset_A got %h want 0", A); end
    n_cmp++; if (B !== 32'd0) begin n_err++; $display("FAIL reset_B got %h want 0", B); end
    n_cmp++; if (ALUControl !== 4'b0010) begin n_err++; $display("FAIL reset_alu got %b want 0010", ALUControl); end
    n_cmp++; if ({EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl got %b want 0000", {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg}); end
    n_cmp++; if (EX_StoreData !== 32'd0 || EX_WriteReg !== 5'd0) begin
      n_err++; $display("FAIL reset_store_wr got %h/%0d want 0/0", EX_StoreData, EX_WriteReg); end
    n_cmp++; if (HazardStall !== 1'b0) begin n_err++; $display("FAIL reset_hazard got %b want 0", HazardStall); end
    rst_n = 1;
    clear_id();
  endtask

  task automatic test_decode();
    logic [1:0] ops [10];
    logic [5:0] fns [10];
    logic [3:0] exp [10];
    ops = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000,
            6'b100100, 6'b100101, 6'b100010};
    exp = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b0010,
            4'b0010, 4'b0110, 4'b0001};
    for (int i = 0; i < 10; i++) begin
      ID_ALUOp = ops[i]; ID_Funct = fns[i];
      tick();
      n_cmp++; if (ALUControl !== exp[i]) begin
        n_err++; $display("FAIL decode_%0d got %b want %b", i, ALUControl, exp[i]); end
    end
  endtask

  task automatic test_fwd_priority();
    clear_id();
    ID_Rs = 5; ID_ReadData1 = 32'hAAAA_0001; ID_RegWrite = 1; ID_RegDst = 1; ID_Rd = 6;
    tick();
    MEM_RegWrite = 1; MEM_WriteReg = 5; MEM_ALUResult = 32'h11;
    WB_RegWrite = 1; WB_WriteReg = 5; WB_Result = 32'h22;
    #1;
    n_cmp++; if (A !== 32'h11) begin n_err++; $display("FAIL fwd_mem_wins got %h want 11", A); end
    MEM_RegWrite = 0; #1;
    n_cmp++; if (A !== 32'h22) begin n_err++; $display("FAIL fwd_wb got %h want 22", A); end
    WB_WriteReg = 0; #1;
    n_cmp++; if (A !== 32'hAAAA_0001) begin n_err++; $display("FAIL fwd_none got %h want aaaa0001", A); end
    WB_RegWrite = 0;
    // Register 0 must never be forwarded.
    clear_id();
    ID_Rs = 0; ID_ReadData1 = 32'h0BAD_0000;
    tick();
    MEM_RegWrite = 1; MEM_WriteReg = 0; MEM_ALUResult = 32'h99;
    WB_RegWrite = 1; WB_WriteReg = 0; WB_Result = 32'h88;
    #1;
    n_cmp++; if (A !== 32'h0BAD_0000) begin n_err++; $display("FAIL fwd_r0 got %h want 0bad0000", A); end
    MEM_RegWrite = 0; WB_RegWrite = 0;
  endtask

  task automatic test_load_use();
    clear_id();
    ID_Rs = 1; ID_Rt = 8; ID_RegDst = 0; ID_RegWrite = 1; ID_MemRead = 1; ID_MemtoReg = 1;
    tick();
    clear_id();
    ID_Rs = 8; ID_Rt = 2; ID_Rd = 10; ID_RegDst = 1; ID_RegWrite = 1;
    ID_ALUOp = 2'b10; ID_Funct = 6'b100010; ID_ReadData1 = 32'h0000_0BAD;
    #1;
    n_cmp++; if (HazardStall !== 1'b1) begin n_err++; $display("FAIL lu_detect got %b want 1", HazardStall); end
    tick();
    n_cmp++; if (EX_RegWrite !== 1'b0 || EX_MemRead !== 1'b0) begin
      n_err++; $display("FAIL lu_bubble got rw=%b mr=%b want 0/0", EX_RegWrite, EX_MemRead); end
    n_cmp++; if (HazardStall !== 1'b0) begin n_err++; $display("FAIL lu_drop got %b want 0", HazardStall); end
    tick();
    n_cmp++; if (EX_WriteReg !== 5'd10 || EX_RegWrite !== 1'b1) begin
      n_err++; $display("FAIL lu_dependent got wr=%0d rw=%b want 10/1", EX_WriteReg, EX_RegWrite); end
    WB_RegWrite = 1; WB_WriteReg = 8; WB_Result = 32'h5555; #1;
    n_cmp++; if (A !== 32'h5555) begin n_err++; $display("FAIL lu_wb_fwd got %h want 5555", A); end
    WB_RegWrite = 0; WB_WriteReg = 0;
  endtask

  task automatic test_stall_flush();
    // EX holds the sub instruction writing r10 from the load-use scenario.
    clear_id();
    ID_Rd = 20; ID_RegDst = 1; ID_RegWrite = 0; ID_ALUOp = 2'b11; ID_MemWrite = 1;
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (EX_WriteReg !== 5'd10 || ALUControl !== 4'b0110 || EX_RegWrite !== 1'b1 || EX_MemWrite !== 1'b0) begin
        n_err++; $display("FAIL stall_hold_%0d got wr=%0d alu=%b rw=%b mw=%b want 10/0110/1/0",
                          i, EX_WriteReg, ALUControl, EX_RegWrite, EX_MemWrite); end
    end
    Flush = 1;
    tick();
    n_cmp++; if (EX_RegWrite !== 1'b0 || EX_WriteReg !== 5'd0 || ALUControl !== 4'b0010) begin
      n_err++; $display("FAIL stall_flush got rw=%b wr=%0d alu=%b want 0/0/0010", EX_RegWrite, EX_WriteReg, ALUControl); end
    Stall = 0; Flush = 0; ID_RegWrite = 1;
    tick();
    Flush = 1;
    tick();
    n_cmp++; if (EX_RegWrite !== 1'b0 || EX_MemWrite !== 1'b0) begin
      n_err++; $display("FAIL flush_only got rw=%b mw=%b want 0/0", EX_RegWrite, EX_MemWrite); end
    Flush = 0;
  endtask

  task automatic test_imm_store();
    clear_id();
    ID_ALUSrc = 1; ID_SignImm = 32'hFFFF_FFFC; ID_Rt = 9; ID_ReadData2 = 32'h77; ID_MemWrite = 1;
    tick();
    MEM_RegWrite = 1; MEM_WriteReg = 9; MEM_ALUResult = 32'h1234; #1;
    n_cmp++; if (B !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL imm_B got %h want fffffffc", B); end
    n_cmp++; if (EX_StoreData !== 32'h1234) begin n_err++; $display("FAIL store_fwd got %h want 1234", EX_StoreData); end
    n_cmp++; if (EX_MemWrite !== 1'b1) begin n_err++; $display("FAIL store_mw got %b want 1", EX_MemWrite); end
    MEM_RegWrite = 0;
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, es;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      Stall = ($urandom_range(0, 5) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_SignImm = $urandom;
      ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3)); ID_Rd = 5'($urandom_range(0, 3));
      ID_ALUOp = 2'($urandom); ID_Funct = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'b100000 + 6'($urandom_range(0, 10));
      ID_ALUSrc = 1'($urandom); ID_RegDst = 1'($urandom); ID_RegWrite = 1'($urandom);
      ID_MemRead = ($urandom_range(0, 2) == 0); ID_MemWrite = 1'($urandom); ID_MemtoReg = 1'($urandom);
      MEM_RegWrite = 1'($urandom); MEM_WriteReg = 5'($urandom_range(0, 3)); MEM_ALUResult = $urandom;
      WB_RegWrite = 1'($urandom); WB_WriteReg = 5'($urandom_range(0, 3)); WB_Result = $urandom;
      #1;
      ea = ref_fwd(m.rs, m.rd1);
      es = ref_fwd(m.rt, m.rd2);
      eb = m.src ? m.imm : es;
      n_cmp++; if (A !== ea || B !== eb || EX_StoreData !== es) begin
        n_err++; $display("FAIL rand_data_%0d got A=%h B=%h S=%h want A=%h B=%h S=%h", i, A, B, EX_StoreData, ea, eb, es); end
      n_cmp++; if (ALUControl !== m.alu || EX_WriteReg !== m.wr) begin
        n_err++; $display("FAIL rand_alu_wr_%0d got %b/%0d want %b/%0d", i, ALUControl, EX_WriteReg, m.alu, m.wr); end
      n_cmp++; if ({EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg} !== {m.rw, m.mr, m.mw, m.m2r}) begin
        n_err++; $display("FAIL rand_ctrl_%0d got %b want %b", i,
                          {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg}, {m.rw, m.mr, m.mw, m.m2r}); end
      n_cmp++; if (HazardStall !== ref_hazard()) begin
        n_err++; $display("FAIL rand_hazard_%0d got %b want %b", i, HazardStall, ref_hazard()); end
      tick();
    end
    rst_n = 1; Stall = 0; Flush = 0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_fwd_priority();
    test_load_use();
    test_stall_flush();
    test_imm_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand front end for the 5-stage MIPS core. Latches decoded instruction fields and control from ID, decodes the 4-bit ALU opcode, and resolves operand forwarding from EX/MEM and MEM/WB. Drives the ALU inputs `A`, `B` and `ALUControl` directly. Also detects load-use hazards and inserts one bubble for each.

## Interface
- No parameters. Data width is fixed at 32, register index width at 5.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `ID_ReadData1`, `ID_ReadData2` in 32 each: register-file read data (rs, rt).
- `ID_SignImm` in 32: sign-extended immediate.
- `ID_Rs`, `ID_Rt`, `ID_Rd` in 5 each: register indices.
- `ID_ALUOp` in 2: main-decoder ALU class.
- `ID_Funct` in 6: instruction funct field.
- `ID_ALUSrc`, `ID_RegDst`, `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemtoReg` in 1 each: control bits from the main decoder.
- `Stall` in 1: external freeze (memory wait); holds the register.
- `Flush` in 1: branch/jump squash; loads a bubble.
- `MEM_RegWrite` in 1, `MEM_WriteReg` in 5, `MEM_ALUResult` in 32: EX/MEM forwarding source.
- `WB_RegWrite` in 1, `WB_WriteReg` in 5, `WB_Result` in 32: MEM/WB forwarding source.
- `A`, `B` out 32 each: ALU operands.
- `ALUControl` out 4: ALU opcode.
- `EX_StoreData` out 32: forwarded rt value, used by `sw`.
- `EX_WriteReg` out 5: destination register.
- `EX_RegWrite`, `EX_MemRead`, `EX_MemWrite`, `EX_MemtoReg` out 1 each: registered control bits.
- `HazardStall` out 1: load-use detected; IF/ID and PC must hold.

## Operation
- Priority of register update, per cycle, highest first:
  1. `!rst_n`: clear.
  2. `Flush`: load bubble.
  3. `Stall`: hold all state.
  4. `HazardStall`: load bubble.
  5. Otherwise: load ID inputs.
- Clear and bubble are identical:
  - All control bits = 0.
  - Data, index and `EX_Rt`/`EX_Rs` registers = 0.
  - `EX_WriteReg` = 0.
  - Latched ALU code = 0010.
- `EX_WriteReg` is latched as `ID_RegDst ? ID_Rd : ID_Rt`.
- ALU decode happens on the ID side and is latched with the other fields:
  - `ID_ALUOp` 00 → 0010 (add).
  - `ID_ALUOp` 01 → 0110 (sub).
  - `ID_ALUOp` 11 → 0001 (or).
  - `ID_ALUOp` 10 decodes `ID_Funct`:
    - 100000 → 0010
    - 100010 → 0110
    - 100100 → 0000
    - 100101 → 0001
    - 101010 → 0111
    - 100111 → 1100
    - any other funct → 0010
- Forwarding for the rs operand (combinational, from registered EX fields):
  - If `MEM_RegWrite` and `MEM_WriteReg` != 0 and `MEM_WriteReg` == `EX_Rs`: use `MEM_ALUResult`.
  - Else if `WB_RegWrite` and `WB_WriteReg` != 0 and `WB_WriteReg` == `EX_Rs`: use `WB_Result`.
  - Else: use latched ReadData1.
  - MEM always wins over WB when both match.
- Forwarding for the rt operand: same rule using `EX_Rt`, producing FwdRt.
- `A` = forwarded rs value.
- `B` = latched ALUSrc ? latched SignImm : FwdRt.
- `EX_StoreData` = FwdRt.
- `HazardStall` (combinational) = `EX_MemRead` & (`EX_Rt` != 0) & (`EX_Rt` == `ID_Rs` | `EX_Rt` == `ID_Rt`).
- `HazardStall` is asserted regardless of `Stall`/`Flush`. Upstream applies the same priority.

## Timing
- Latency: ID inputs appear on the EX outputs one cycle after the edge that samples them.
- `A`, `B` and `EX_StoreData` are combinational from the registers and the forwarding inputs. No extra cycle.
- Reset values (visible the cycle after reset is sampled):
  - `A` = 0, `B` = 0, `ALUControl` = 0010.
  - `EX_StoreData` = 0, `EX_WriteReg` = 0.
  - All `EX_*` control bits = 0.
  - `HazardStall` = 0.
- Load-use: exactly one bubble per load-use pair.
  - The cycle after the bubble, `EX_MemRead` = 0, so `HazardStall` drops.
  - The held ID instruction then loads.
  - The loaded value reaches it via WB forwarding.
- `Stall` high for N cycles holds the register contents for N edges. The forwarding muxes keep tracking live MEM/WB inputs.
- `Flush` and `Stall` in the same cycle: the bubble is loaded.
- `rst_n` low mid-stall or mid-hazard: cleared on that edge. No pending state survives.
- Register 0 is never forwarded, even when the MEM/WB source writes reg 0.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with nonzero ID inputs → `A` = 0, `B` = 0, `ALUControl` = 0010, all `EX_*` control bits = 0.
- **Decode:**
  - ALUOp = 10 with each funct 100000, 100010, 100100, 100101, 101010, 100111, 000000 → `ALUControl` = 0010, 0110, 0000, 0001, 0111, 1100, 0010, one cycle later.
  - ALUOp = 00, 01, 11 → 0010, 0110, 0001.
- **Forward priority:** `EX_Rs` = 5; MEM writes r5 = 0x11; WB writes r5 = 0x22 → `A` = 0x11. Drop `MEM_RegWrite` → `A` = 0x22. Set `WB_WriteReg` = 0 → `A` = latched ReadData1.
- **Load-use:**
  - `lw` r8 in EX while ID has rs = 8 → `HazardStall` = 1.
  - Next cycle: EX holds a bubble (`EX_RegWrite` = 0, `EX_MemRead` = 0) and `HazardStall` = 0.
  - Following cycle: EX holds the dependent instruction.
- **Stall vs Flush:**
  - `Stall` = 1 for 3 cycles → outputs frozen.
  - `Stall` = 1 and `Flush` = 1 together → bubble loaded.
  - `Flush` alone → bubble, with `ID_RegWrite` = 1 ignored.
- **Immediate / store path:** `ID_ALUSrc` = 1, SignImm = 0xFFFFFFFC, rt forwarded 0x1234 from MEM → `B` = 0xFFFFFFFC, `EX_StoreData` = 0x1234.
